transmit: RTL

TRANSMIT -- requirements
Module: transmit

---
 rtl/frame_pkg.sv | 26 ++
 rtl/transmit_if.sv | 18 +
 rtl/crc8_serial.sv | 26 ++
 rtl/transmit.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/frame_pkg.sv
// Shared framing definitions for the serial transmitter and its receiver:
// state encoding, stuffing run length, CRC polynomial and fixed line levels.
package frame_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_START = 3'd1;
  localparam state_t ST_SIZE  = 3'd2;
  localparam state_t ST_DATA  = 3'd3;
  localparam state_t ST_CRC   = 3'd4;
  localparam state_t ST_STOP  = 3'd5;

  localparam logic [7:0] CRC_POLY  = 8'h07;
  localparam logic [2:0] STUFF_RUN = 3'd5;

  localparam logic BIT_IDLE  = 1'b0;
  localparam logic BIT_START = 1'b1;
  localparam logic BIT_STOP  = 1'b0;

  // One MSB-first step of CRC-8 (x^8+x^2+x+1), no reflection.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
    return {crc[6:0], 1'b0} ^ (((crc[7] ^ b) == 1'b1) ? CRC_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/transmit_if.sv
// Handshake and serial-line bundle between a frame source and the transmitter.
interface transmit_if;
  logic [7:0] baudrate;
  logic       start;
  logic [3:0] framesize;
  logic [7:0] datain;
  logic       dvalid;
  logic       dreq;
  logic       tx;
  logic       busy;
  logic       done;
  logic       ur;

  modport master (output baudrate, start, framesize, datain, dvalid,
                  input  dreq, tx, busy, done, ur);
  modport slave  (input  baudrate, start, framesize, datain, dvalid,
                  output dreq, tx, busy, done, ur);
endinterface

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 accumulator, fed one data bit per enable.
module crc8_serial
  import frame_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       en,
  input  logic       bit_i,
  output logic [7:0] crc
);

  logic [7:0] crc_q;

  // Accumulator: cleared at frame start, advanced once per transmitted data bit.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      crc_q <= 8'h00;
    end else if (en) begin
      crc_q <= crc8_step(crc_q, bit_i);
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/transmit.sv
// Framed serial transmitter with bit stuffing and a one-byte holding register.
// Define TX_CRC_EN to append a CRC-8 over the data bits before the stop bit.
module transmit
  import frame_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  transmit_if.slave bus
);

  state_t     state_q, state_d;
  logic [7:0] baud_q, baud_d, cnt_q, cnt_d, sh_q, sh_d, hold_q, hold_d;
  logic [3:0] fsize_q, fsize_d, left_q, left_d, acc_q, acc_d;
  logic [2:0] idx_q, idx_d, run_len_q, run_len_d;
  logic       tx_q, tx_d, busy_q, busy_d, done_q, done_d, ur_q, ur_d, dreq_q, dreq_d;
  logic       hold_vld_q, hold_vld_d, run_val_q, run_val_d;
  logic       xfer_s, load_s, next_byte_s, end_data_s, to_stop_s, bit_s;

`ifdef TX_CRC_EN
  logic [7:0] crc_s;

  crc8_serial u_crc (
    .clk   (clk),
    .reset (reset),
    .clear ((state_q == ST_IDLE) && bus.start),
    .en    (load_s && (state_d == ST_DATA)),
    .bit_i (bit_s),
    .crc   (crc_s)
  );
`endif

  // Next-state: bit timing, field sequencing, stuffing and the byte handshake.
  always_comb begin
    state_d = state_q;  baud_d = baud_q;  cnt_d = cnt_q;  tx_d = tx_q;  ur_d = ur_q;
    fsize_d = fsize_q;  left_d = left_q;  acc_d = acc_q;  idx_d = idx_q;  sh_d = sh_q;
    hold_d = hold_q;    hold_vld_d = hold_vld_q;
    run_val_d = run_val_q;  run_len_d = run_len_q;
    load_s = 1'b0;  next_byte_s = 1'b0;  end_data_s = 1'b0;  to_stop_s = 1'b0;  bit_s = 1'b0;
    xfer_s = bus.dvalid && dreq_q;

    if (xfer_s) begin
      hold_d = bus.datain;  hold_vld_d = 1'b1;  acc_d = acc_q + 4'd1;
    end else begin
      hold_vld_d = hold_vld_q;
    end

    if (state_q == ST_IDLE) begin
      if (bus.start) begin
        state_d = ST_START;
        baud_d  = (bus.baudrate == 8'd0) ? 8'd1 : bus.baudrate;
        cnt_d   = baud_d - 8'd1;
        tx_d    = BIT_START;
        fsize_d = bus.framesize;  left_d = bus.framesize;  acc_d = 4'd0;
        hold_vld_d = 1'b0;  run_len_d = 3'd0;  ur_d = 1'b0;
      end else begin
        state_d = ST_IDLE;
      end
    end else if (cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end else if (state_q == ST_STOP) begin
      state_d = ST_IDLE;
      tx_d    = BIT_IDLE;
    end else if (run_len_q == STUFF_RUN) begin
      // Stuff bit: field position is left alone, it opens a new run.
      tx_d = ~run_val_q;  run_val_d = ~run_val_q;  run_len_d = 3'd1;
      cnt_d = baud_q - 8'd1;
    end else begin
      cnt_d = baud_q - 8'd1;
      case (state_q)
        ST_START: begin state_d = ST_SIZE; idx_d = 3'd3; load_s = 1'b1; end
        ST_SIZE: begin
          if (idx_q != 3'd0)        begin idx_d = idx_q - 3'd1; load_s = 1'b1; end
          else if (fsize_q != 4'd0) next_byte_s = 1'b1;
          else                      end_data_s = 1'b1;
        end
        ST_DATA: begin
          if (idx_q != 3'd0)       begin idx_d = idx_q - 3'd1; load_s = 1'b1; end
          else if (left_q != 4'd0) next_byte_s = 1'b1;
          else                     end_data_s = 1'b1;
        end
`ifdef TX_CRC_EN
        ST_CRC: begin
          if (idx_q != 3'd0) begin idx_d = idx_q - 3'd1; load_s = 1'b1; end
          else               to_stop_s = 1'b1;
        end
`endif
        default: to_stop_s = 1'b1;
      endcase

      if (next_byte_s) begin
        if (hold_vld_q || xfer_s) begin
          state_d = ST_DATA;  idx_d = 3'd7;  left_d = left_q - 4'd1;  load_s = 1'b1;
          sh_d = hold_vld_q ? hold_q : bus.datain;
          hold_vld_d = 1'b0;
        end else begin
          ur_d = 1'b1;  to_stop_s = 1'b1;
        end
      end else begin
        sh_d = sh_q;
      end

      if (end_data_s) begin
`ifdef TX_CRC_EN
        state_d = ST_CRC;  idx_d = 3'd7;  load_s = 1'b1;
`else
        to_stop_s = 1'b1;
`endif
      end else begin
        idx_d = idx_d;
      end

      if (to_stop_s) begin
        state_d = ST_STOP;  tx_d = BIT_STOP;
      end else begin
        tx_d = tx_q;
      end

      if (load_s) begin
        case (state_d)
          ST_SIZE: bit_s = fsize_q[idx_d[1:0]];
          ST_DATA: bit_s = sh_d[idx_d];
`ifdef TX_CRC_EN
          ST_CRC:  bit_s = crc_s[idx_d];
`endif
          default: bit_s = 1'b0;
        endcase
        tx_d = bit_s;
        if ((run_len_q != 3'd0) && (bit_s == run_val_q)) begin
          run_len_d = run_len_q + 3'd1;
        end else begin
          run_val_d = bit_s;  run_len_d = 3'd1;
        end
      end else begin
        run_len_d = run_len_d;
      end
    end

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_STOP) && (cnt_d == 8'd0);
    dreq_d = ((state_d == ST_START) || (state_d == ST_SIZE) || (state_d == ST_DATA))
             && !hold_vld_d && (acc_d != fsize_d);
  end

  // State and output registers; reset overrides any start request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;  baud_q <= 8'd1;  cnt_q <= 8'd0;  sh_q <= 8'd0;  hold_q <= 8'd0;
      fsize_q <= 4'd0;  left_q <= 4'd0;  acc_q <= 4'd0;  idx_q <= 3'd0;  run_len_q <= 3'd0;
      tx_q <= BIT_IDLE;  busy_q <= 1'b0;  done_q <= 1'b0;  ur_q <= 1'b0;  dreq_q <= 1'b0;
      hold_vld_q <= 1'b0;  run_val_q <= 1'b0;
    end else begin
      state_q <= state_d;  baud_q <= baud_d;  cnt_q <= cnt_d;  sh_q <= sh_d;  hold_q <= hold_d;
      fsize_q <= fsize_d;  left_q <= left_d;  acc_q <= acc_d;  idx_q <= idx_d;  run_len_q <= run_len_d;
      tx_q <= tx_d;  busy_q <= busy_d;  done_q <= done_d;  ur_q <= ur_d;  dreq_q <= dreq_d;
      hold_vld_q <= hold_vld_d;  run_val_q <= run_val_d;
    end
  end

  assign bus.tx   = tx_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.ur   = ur_q;
  assign bus.dreq = dreq_q;

endmodule
